instr_fetch_unit: RTL and testbench

//  Consumer side of the program counter. Owns the fetch PC and issues in-order

---
 rtl/ifu_pkg.sv | 21 ++
 rtl/instr_fetch_unit_fetch_queue.sv | 64 ++++++
 rtl/instr_fetch_unit.sv | 159 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
//   fetch_state_e : FETCH (issuing requests) / DRAIN (dropping responses that are stale after a redirect)
//   ifu_entry_t   : one prefetch queue entry, the instruction word tagged with its PC
//   INSTR_BYTES   : PC increment per fetched word
package ifu_pkg;

    localparam int IFU_ADDR_W  = 32;
    localparam int IFU_INSTR_W = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [IFU_ADDR_W-1:0]  pc;
        logic [IFU_INSTR_W-1:0] instr;
    } ifu_entry_t;

endpackage

// File: rtl/instr_fetch_unit_fetch_queue.sv
// fetch_queue: synchronous FIFO of ifu_entry_t used as the prefetch queue.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   push, push_entry   write one entry at the tail
//   pop                remove the head (caller guarantees non-empty)
//   flush              discard every entry; takes priority over push/pop
//   head               entry at the head (meaningful only when !empty)
//   count, empty       occupancy
module fetch_queue
    import ifu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  ifu_entry_t               push_entry,
    input  logic                     pop,
    input  logic                     flush,
    output ifu_entry_t               head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    ifu_entry_t       mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W + 1){1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + {{(PTR_W - 1){1'b0}}, 1'b1};
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W - 1){1'b0}}, 1'b1};
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + {{PTR_W{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{PTR_W{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents need no reset because empty masks them
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) begin
            mem_r[wr_ptr_r] <= push_entry;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign empty = (count_r == {(PTR_W + 1){1'b0}});

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the fetch PC, issues in-order instruction memory reads
// under a credit limit and hands returned words to decode through a prefetch queue.
// Optional feature macro: IFU_PERF_CNT_EN enables the decode-starve counter
// (perf_stall_cnt); without it the port is tied to zero.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   redirect_valid, redirect_pc     branch/exception redirect (pc[1:0] ignored)
//   imem_req_valid/ready/addr       fetch request handshake, addr = current PC
//   imem_rsp_valid/data             in-order response words
//   id_valid/ready, id_instr, id_pc queue head to decode
//   busy                            requests in flight or queue non-empty
//   perf_stall_cnt                  cycles decode was ready but starved
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                INSTR_W     = 32,
    parameter int                QUEUE_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC    = {ADDR_W{1'b0}}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc,
    output logic               busy,
    output logic [31:0]        perf_stall_cnt
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    logic [ADDR_W-1:0] pc_r;
    fetch_state_e      state_r;
    logic [CNT_W-1:0]  inflight_r;
    logic [CNT_W-1:0]  discard_r;

    logic              credit_ok_s;
    logic              req_fire_s;
    logic              rsp_fire_s;
    logic              push_s;
    logic              pop_s;
    logic [CNT_W-1:0]  inflight_next_s;
    logic [CNT_W-1:0]  inflight_less_rsp_s;
    logic [ADDR_W-1:0] rsp_pc_s;
    ifu_entry_t        push_entry_s;
    ifu_entry_t        head_s;
    logic [CNT_W-1:0]  q_count_s;
    logic              q_empty_s;

    // Credit rule: queued words plus outstanding requests never exceed the queue size
    assign credit_ok_s = ({1'b0, inflight_r} + {1'b0, q_count_s}) < (CNT_W + 1)'(QUEUE_DEPTH);

    // Handshakes and queue control; imem and decode interfaces are forced idle during reset
    always_comb begin
        imem_req_valid = !reset && (state_r == FETCH) && !redirect_valid && credit_ok_s;
        imem_req_addr  = reset ? RESET_PC : pc_r;
        req_fire_s     = imem_req_valid && imem_req_ready;
        rsp_fire_s     = imem_rsp_valid && (inflight_r != {CNT_W{1'b0}});
        push_s         = rsp_fire_s && (state_r == FETCH) && !redirect_valid;
        id_valid       = !reset && !q_empty_s;
        pop_s          = id_valid && id_ready;
        id_instr       = id_valid ? INSTR_W'(head_s.instr) : {INSTR_W{1'b0}};
        id_pc          = id_valid ? ADDR_W'(head_s.pc) : {ADDR_W{1'b0}};
        busy           = !reset && ((inflight_r != {CNT_W{1'b0}}) || !q_empty_s);
    end

    // Responses return in order, so in FETCH the oldest outstanding PC is pc minus the in-flight bytes
    always_comb begin
        rsp_pc_s           = pc_r - (ADDR_W'(inflight_r) * ADDR_W'(INSTR_BYTES));
        push_entry_s.pc    = IFU_ADDR_W'(rsp_pc_s);
        push_entry_s.instr = IFU_INSTR_W'(imem_rsp_data);
    end

    // Outstanding-request count: accept and response in the same cycle cancel out
    always_comb begin
        inflight_less_rsp_s = inflight_r - CNT_W'(rsp_fire_s);
        case ({req_fire_s, rsp_fire_s})
            2'b10:   inflight_next_s = inflight_r + {{(CNT_W - 1){1'b0}}, 1'b1};
            2'b01:   inflight_next_s = inflight_r - {{(CNT_W - 1){1'b0}}, 1'b1};
            default: inflight_next_s = inflight_r;
        endcase
    end

    // PC, in-flight/discard counters and FETCH/DRAIN state
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r       <= RESET_PC;
            state_r    <= FETCH;
            inflight_r <= {CNT_W{1'b0}};
            discard_r  <= {CNT_W{1'b0}};
        end else begin
            inflight_r <= inflight_next_s;
            if (redirect_valid) begin
                pc_r <= redirect_pc & ~ADDR_W'(INSTR_BYTES - 1);
            end else if (req_fire_s) begin
                pc_r <= pc_r + ADDR_W'(INSTR_BYTES);
            end
            case (state_r)
                FETCH: begin
                    // Every request still outstanding after this cycle now targets a dead path
                    if (redirect_valid) begin
                        discard_r <= inflight_less_rsp_s;
                        state_r   <= (inflight_less_rsp_s != {CNT_W{1'b0}}) ? DRAIN : FETCH;
                    end
                end
                DRAIN: begin
                    discard_r <= discard_r - CNT_W'(rsp_fire_s);
                    if (discard_r == {CNT_W{1'b0}}) begin
                        state_r <= FETCH;
                    end
                end
                default: begin
                    state_r   <= FETCH;
                    discard_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .flush      (redirect_valid),
        .head       (head_s),
        .count      (q_count_s),
        .empty      (q_empty_s)
    );

`ifdef IFU_PERF_CNT_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of cycles where decode was ready but had nothing to take
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= 32'd0;
        end else if (id_ready && !id_valid && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt_r;
`else
    assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        busy;
    logic [31:0] perf_stall_cnt;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W      (32),
        .INSTR_W     (32),
        .QUEUE_DEPTH (4),
        .RESET_PC    (32'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .busy           (busy),
        .perf_stall_cnt (perf_stall_cnt)
    );

    typedef struct { logic [31:0] addr; int due; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

    pend_t       pend[$];
    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rsp_lat = 1;
    int          n_acc, n_hs, n_rsp;
    int          first_id_cyc, last_acc_cyc, last_rsp_cyc, last_hs_cyc;
    logic [31:0] exp_pc, last_acc_addr, last_hs_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    // One clock cycle: imem model drives responses, scoreboard pushes on accept and pops on decode handshake
    task automatic tick();
        pend_t p;
        exp_t  e;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            p = pend.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(p.addr);
            n_rsp++;
            last_rsp_cyc = cyc;
        end
        #1;
        if (id_valid === 1'b1 && first_id_cyc < 0) first_id_cyc = cyc;
        if (id_valid === 1'b1 && id_ready === 1'b1) begin
            n_hs++;
            last_hs_cyc = cyc;
            last_hs_pc  = id_pc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_unexpected: id_pc=%h id_instr=%h, expected no word", id_pc, id_instr);
            end else begin
                e = exp_q.pop_front();
                if (id_pc !== e.pc || id_instr !== e.instr) begin
                    errors++;
                    $display("FAIL scoreboard_id: got pc=%h instr=%h, expected pc=%h instr=%h",
                             id_pc, id_instr, e.pc, e.instr);
                end
            end
        end
        if (imem_req_valid === 1'b1 && imem_req_ready === 1'b1) begin
            checks++;
            if (imem_req_addr !== exp_pc) begin
                errors++;
                $display("FAIL req_addr: got %h, expected %h", imem_req_addr, exp_pc);
            end
            p.addr = imem_req_addr;
            p.due  = cyc + rsp_lat;
            pend.push_back(p);
            e.pc    = exp_pc;
            e.instr = mem_word(exp_pc);
            exp_q.push_back(e);
            exp_pc        = exp_pc + 32'd4;
            n_acc++;
            last_acc_cyc  = cyc;
            last_acc_addr = imem_req_addr;
        end
        if (redirect_valid) begin
            exp_q.delete();
            exp_pc = redirect_pc & 32'hFFFF_FFFC;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        id_ready       = 1'b0;
        repeat (2) @(negedge clk);
        pend.delete();
        exp_q.delete();
        exp_pc = 32'h0; n_acc = 0; n_hs = 0; n_rsp = 0;
        first_id_cyc = -1; last_acc_cyc = -1; last_rsp_cyc = -1; last_hs_cyc = -1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    // Let everything outstanding come back and leave decode, then confirm nothing is left over
    task automatic drain();
        imem_req_ready = 1'b0;
        id_ready       = 1'b1;
        for (int i = 0; i < 100 && (busy !== 1'b0 || pend.size() != 0); i++) tick();
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: busy=%b words_left=%0d, expected busy=0 words_left=0", busy, exp_q.size());
        end
    endtask

    task automatic test_reset();
        // asserted mid-stream: interfaces must go idle in the same cycle
        reset = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_same_cycle: req_valid=%b id_valid=%b, expected 0 0", imem_req_valid, id_valid);
        end
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0 || id_valid !== 1'b0 || id_instr !== 32'h0 ||
            id_pc !== 32'h0 || busy !== 1'b0 || perf_stall_cnt !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: req_valid=%b addr=%h id_valid=%b instr=%h pc=%h busy=%b perf=%0d, expected all 0",
                     imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, busy, perf_stall_cnt);
        end
        apply_reset();
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || busy !== 1'b0 || id_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: req_valid=%b addr=%h busy=%b id_valid=%b, expected 1 0 0 0",
                     imem_req_valid, imem_req_addr, busy, id_valid);
        end
        @(negedge clk);
        apply_reset();
    endtask

    task automatic test_stream();
        apply_reset();
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        rsp_lat        = 1;
        repeat (20) tick();
        checks++;
        if (first_id_cyc != 2) begin
            errors++;
            $display("FAIL stream_latency: first id_valid at cycle %0d, expected 2", first_id_cyc);
        end
        checks++;
        if (n_acc != 20 || n_hs != 18) begin
            errors++;
            $display("FAIL stream_rate: accepts=%0d handshakes=%0d, expected 20 18", n_acc, n_hs);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        imem_req_ready = 1'b1;
        id_ready       = 1'b0;
        rsp_lat        = 1;
        repeat (8) tick();
        checks++;
        if (n_acc != 4 || last_acc_addr !== 32'hC) begin
            errors++;
            $display("FAIL credit_cap: accepts=%0d last_addr=%h, expected 4 0000000c", n_acc, last_acc_addr);
        end
        checks++;
        if (imem_req_valid !== 1'b0 || id_valid !== 1'b1) begin
            errors++;
            $display("FAIL queue_full: req_valid=%b id_valid=%b, expected 0 1", imem_req_valid, id_valid);
        end
        id_ready = 1'b1;
        for (int i = 0; i < 20 && n_acc < 5; i++) tick();
        checks++;
        if (n_acc != 5 || last_acc_addr !== 32'h10) begin
            errors++;
            $display("FAIL resume_addr: accepts=%0d last_addr=%h, expected 5 00000010", n_acc, last_acc_addr);
        end
        drain();
    endtask

    task automatic test_req_stall();
        apply_reset();
        imem_req_ready = 1'b0;
        id_ready       = 1'b1;
        rsp_lat        = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
                errors++;
                $display("FAIL req_hold: cycle %0d valid=%b addr=%h, expected 1 00000000", i, imem_req_valid, imem_req_addr);
            end
            tick();
        end
        imem_req_ready = 1'b1;
        tick();
        checks++;
        if (n_acc != 1 || last_acc_cyc != 3 || last_acc_addr !== 32'h0) begin
            errors++;
            $display("FAIL req_accept: accepts=%0d cycle=%0d addr=%h, expected 1 3 00000000", n_acc, last_acc_cyc, last_acc_addr);
        end
        drain();
    endtask

    task automatic test_redirect_drain();
        int rsp_before, hs_before;
        apply_reset();
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        rsp_lat        = 3;
        tick();
        tick();
        checks++;
        if (n_acc != 2 || n_rsp != 0) begin
            errors++;
            $display("FAIL redirect_setup: accepts=%0d responses=%0d, expected 2 0", n_acc, n_rsp);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_blocks_req: req_valid=%b, expected 0", imem_req_valid);
        end
        tick();
        redirect_valid = 1'b0;
        rsp_before = n_rsp;
        hs_before  = n_hs;
        for (int i = 0; i < 30 && n_acc < 3; i++) tick();
        checks++;
        if (n_acc != 3 || last_acc_addr !== 32'h100 || n_rsp - rsp_before != 2 || n_hs != hs_before) begin
            errors++;
            $display("FAIL drain_discard: accepts=%0d addr=%h dropped=%0d handshakes=%0d, expected 3 00000100 2 %0d",
                     n_acc, last_acc_addr, n_rsp - rsp_before, n_hs, hs_before);
        end
        for (int i = 0; i < 30 && n_hs == hs_before; i++) tick();
        checks++;
        if (n_hs == hs_before || last_hs_pc !== 32'h100) begin
            errors++;
            $display("FAIL redirect_target: handshakes=%0d id_pc=%h, expected >%0d 00000100", n_hs, last_hs_pc, hs_before);
        end
        drain();
    endtask

    task automatic test_redirect_handshake();
        apply_reset();
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        rsp_lat        = 2;
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (last_rsp_cyc != 3 || last_hs_cyc != 3 || n_hs != 1) begin
            errors++;
            $display("FAIL redirect_collision: rsp_cycle=%0d hs_cycle=%0d handshakes=%0d, expected 3 3 1",
                     last_rsp_cyc, last_hs_cyc, n_hs);
        end
        checks++;
        if (id_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_empty: id_valid=%b, expected 0", id_valid);
        end
        for (int i = 0; i < 30 && n_acc < 4; i++) tick();
        checks++;
        if (n_acc != 4 || last_acc_addr !== 32'h100) begin
            errors++;
            $display("FAIL redirect_align: accepts=%0d addr=%h, expected 4 00000100", n_acc, last_acc_addr);
        end
        drain();
    endtask

    task automatic test_perf();
        logic [31:0] exp_cnt;
`ifdef IFU_PERF_CNT_EN
        exp_cnt = 32'd10;
`else
        exp_cnt = 32'd0;
`endif
        apply_reset();
        imem_req_ready = 1'b0;
        id_ready       = 1'b1;
        repeat (10) tick();
        checks++;
        if (perf_stall_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL perf_stall: got %0d, expected %0d", perf_stall_cnt, exp_cnt);
        end
        drain();
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        id_ready       = 1'b0;
        @(negedge clk);
        test_stream();
        test_reset();
        test_backpressure();
        test_req_stall();
        test_redirect_drain();
        test_redirect_handshake();
        test_perf();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
